// File: rtl/debug_regdump_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debug_regdump_tx                                                |
// | Purpose  : Walks registers 0..NUM_REGS-1 of the register bank via its      |
// |            debug read port, snapshots each word and streams it MSB-byte    |
// |            first into a byte transmitter using a start/busy handshake.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module debug_regdump_tx #(
  parameter int ADDR_BITS = 5,
  parameter int WORD_WIDE = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] regAddr,
  input  logic [WORD_WIDE-1:0] regData,
  output logic [7:0]           txData,
  output logic                 txStart,
  input  logic                 txBusy,
  output logic                 busy,
  output logic                 done
);

  localparam int                   C_NBYTES    = WORD_WIDE / 8;
  localparam int                   C_BI_W      = (C_NBYTES > 1) ? $clog2(C_NBYTES) : 1;
  localparam logic [C_BI_W-1:0]    C_LAST_BYTE = C_BI_W'(C_NBYTES - 1);
  localparam logic [ADDR_BITS-1:0] C_LAST_ADDR = ADDR_BITS'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                r_state, w_state_nx;
  logic [ADDR_BITS-1:0]  r_addr, w_addr_nx;
  logic [WORD_WIDE-1:0]  r_snap, w_snap_nx;
  logic [C_BI_W-1:0]     r_byte_idx, w_byte_idx_nx;
  logic [7:0]            r_tx_data, w_tx_data_nx;
  logic                  r_tx_start, w_tx_start_nx;
  logic [WORD_WIDE-1:0]  w_snap_shifted;
  logic [7:0]            w_cur_byte;

  // Select the current snapshot byte, byte 0 being the most significant one.
  always_comb begin
    w_snap_shifted = r_snap << {r_byte_idx, 3'b000};
    w_cur_byte     = w_snap_shifted[WORD_WIDE-1 -: 8];
  end

  // Next-state and datapath updates; txStart defaults low so it only pulses.
  always_comb begin
    w_state_nx    = r_state;
    w_addr_nx     = r_addr;
    w_snap_nx     = r_snap;
    w_byte_idx_nx = r_byte_idx;
    w_tx_data_nx  = r_tx_data;
    w_tx_start_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_LOAD;
          w_addr_nx  = '0;
        end
      end
      S_LOAD: begin
        // Address has been stable for a cycle, so the bank read data is valid.
        w_snap_nx     = regData;
        w_byte_idx_nx = '0;
        w_state_nx    = S_SEND;
      end
      S_SEND: begin
        if (!txBusy) begin
          w_tx_data_nx  = w_cur_byte;
          w_tx_start_nx = 1'b1;
          w_state_nx    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (txBusy) begin
          w_state_nx = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!txBusy) begin
          if (r_byte_idx != C_LAST_BYTE) begin
            w_byte_idx_nx = r_byte_idx + 1'b1;
            w_state_nx    = S_SEND;
          end else begin
            w_state_nx = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (r_addr == C_LAST_ADDR) begin
          w_state_nx = S_DONE;
        end else begin
          w_addr_nx  = r_addr + 1'b1;
          w_state_nx = S_LOAD;
        end
      end
      S_DONE: begin
        // busy is already low here, so a start in this cycle begins a new run.
        w_addr_nx = '0;
        if (start) begin
          w_state_nx = S_LOAD;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_addr_nx  = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any dump.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_snap     <= '0;
      r_byte_idx <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_addr     <= w_addr_nx;
      r_snap     <= w_snap_nx;
      r_byte_idx <= w_byte_idx_nx;
      r_tx_data  <= w_tx_data_nx;
      r_tx_start <= w_tx_start_nx;
    end
  end

  // busy drops in the DONE cycle so it falls together with the done pulse.
  always_comb begin
    regAddr = r_addr;
    txData  = r_tx_data;
    txStart = r_tx_start;
    busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    done    = (r_state == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_regdump_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_debug_regdump_tx                                             |
// | Purpose  : Self-checking bench for debug_regdump_tx with a reference model |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_debug_regdump_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- instance A: two registers, full model ----------------
  logic        rst_a = 1'b1, start_a = 1'b0;
  logic        txStart_a, txBusy_a, busy_a, done_a;
  logic [4:0]  regAddr_a;
  logic [31:0] regData_a;
  logic [7:0]  txData_a;
  logic [31:0] mem [32];

  assign regData_a = mem[regAddr_a];

  debug_regdump_tx #(.ADDR_BITS(5), .WORD_WIDE(32), .NUM_REGS(2)) dut_a (
    .clock(clk), .reset(rst_a), .start(start_a), .regAddr(regAddr_a),
    .regData(regData_a), .txData(txData_a), .txStart(txStart_a),
    .txBusy(txBusy_a), .busy(busy_a), .done(done_a)
  );

  // Transmitter: busy for tx_len cycles starting the cycle after txStart.
  int   tx_len  = 10;
  int   tx_cnt  = 0;
  logic tx_hold = 1'b0;
  always @(posedge clk) begin
    if (txStart_a === 1'b1) tx_cnt <= tx_len;
    else if (tx_cnt > 0)    tx_cnt <= tx_cnt - 1;
  end
  assign txBusy_a = (tx_cnt > 0) || tx_hold;

  // Reference model state
  logic [7:0] q_b[$];
  int         q_addr[$];
  logic [7:0] got_a[$];
  int cyc = 0, done_at = -1, acc_cyc = 0, n_done_a = 0;
  bit m_busy = 0, m_armed = 0, m_rst_prev = 0, m_inflight = 0;
  bit m_prev_line = 0, m_first = 0, m_line_hi = 0;

  // Compare DUT against the model, then advance the model by one cycle.
  always @(negedge clk) begin
    bit          nx_busy;
    logic [31:0] w;
    if (m_armed && m_rst_prev) begin
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_txStart", txStart_a, 0);
      chk("rst_regAddr", regAddr_a, 0);
      chk("rst_txData", txData_a, 0);
    end else if (m_armed) begin
      chk("busy", busy_a, m_busy);
      chk("done", done_a, (cyc == done_at));
      if (!m_busy && cyc != done_at) chk("idle_regAddr", regAddr_a, 0);
      if (done_a) begin
        n_done_a++;
        chk("done_all_bytes_sent", q_b.size(), 0);
      end
      if (txStart_a) begin
        got_a.push_back(txData_a);
        chk("txStart_line_idle", m_prev_line, 0);
        chk("txStart_one_outstanding", m_inflight, 0);
        chk("txStart_expected", (q_b.size() != 0), 1);
        if (q_b.size() != 0) begin
          chk("txData", txData_a, q_b[0]);
          chk("regAddr_at_byte", regAddr_a, q_addr[0]);
          if (m_first && !m_line_hi) chk("start_latency", cyc - acc_cyc, 3);
          void'(q_b.pop_front());
          void'(q_addr.pop_front());
        end
        m_first    = 0;
        m_inflight = 1;
      end
    end
    // byte completion: transmitter line falls after an accepted byte
    if (m_inflight && m_prev_line && !txBusy_a) begin
      m_inflight = 0;
      if (m_busy && q_b.size() == 0) done_at = cyc + 2;
    end
    m_line_hi = m_line_hi | txBusy_a;
    nx_busy = m_busy;
    if (cyc + 1 == done_at) nx_busy = 0;
    if (rst_a) begin
      nx_busy    = 0;
      done_at    = -1;
      m_inflight = 0;
      q_b.delete();
      q_addr.delete();
    end else if (m_armed && !m_busy && start_a) begin
      nx_busy   = 1;
      acc_cyc   = cyc;
      m_first   = 1;
      m_line_hi = 0;
      for (int a = 0; a < 2; a++) begin
        w = mem[a];
        for (int b = 0; b < 4; b++) begin
          q_b.push_back(w[31 - 8*b -: 8]);
          q_addr.push_back(a);
        end
      end
    end
    m_busy      = nx_busy;
    m_rst_prev  = rst_a;
    m_prev_line = txBusy_a;
    if (rst_a) m_armed = 1;
    cyc++;
  end

  // ---------------- instance B: default parameters, zero bank ----------------
  logic        rst_b = 1'b1, start_b = 1'b0;
  logic        txStart_b, txBusy_b, busy_b, done_b;
  logic [4:0]  regAddr_b;
  logic [31:0] regData_b;
  logic [7:0]  txData_b;
  assign regData_b = '0;

  debug_regdump_tx dut_b (
    .clock(clk), .reset(rst_b), .start(start_b), .regAddr(regAddr_b),
    .regData(regData_b), .txData(txData_b), .txStart(txStart_b),
    .txBusy(txBusy_b), .busy(busy_b), .done(done_b)
  );

  int txb_cnt = 0;
  always @(posedge clk) begin
    if (txStart_b === 1'b1) txb_cnt <= 2;
    else if (txb_cnt > 0)   txb_cnt <= txb_cnt - 1;
  end
  assign txBusy_b = (txb_cnt > 0);

  int nb_bytes = 0, nb_done = 0, nb_maxaddr = 0;
  // Every byte is zero and its address follows byte count / 4.
  always @(negedge clk) begin
    if (!rst_b) begin
      if (txStart_b) begin
        chk("b_txData", txData_b, 0);
        chk("b_regAddr", regAddr_b, nb_bytes / 4);
        nb_bytes++;
        if (int'(regAddr_b) > nb_maxaddr) nb_maxaddr = int'(regAddr_b);
      end
      if (done_b) nb_done++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic wait_bytes_a(input int n);
    int t = 0;
    while (got_a.size() < n && t < 3000) begin
      tick(1);
      t++;
    end
    chk("wait_bytes_in_time", (got_a.size() >= n), 1);
  endtask

  task automatic wait_done_a();
    int d0 = n_done_a;
    int t  = 0;
    while (n_done_a == d0 && t < 3000) begin
      tick(1);
      t++;
    end
    chk("wait_done_in_time", (n_done_a > d0), 1);
  endtask

  logic [7:0] exp1 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hA5, 8'h00, 8'h01};
  int base, base2, d0, t;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0] = 32'h11223344;
    mem[1] = 32'hA5A50001;
    tick(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick(1);
    chk("b_reset_busy", busy_b, 0);
    chk("b_reset_done", done_b, 0);
    chk("b_reset_regAddr", regAddr_b, 0);
    chk("b_reset_txStart", txStart_b, 0);

    // 1: basic two-register dump
    base = got_a.size(); d0 = n_done_a;
    pulse_start_a();
    wait_done_a();
    tick(3);
    chk("t1_count", got_a.size() - base, 8);
    chk("t1_done_count", n_done_a - d0, 1);
    for (int i = 0; i < 8; i++) chk("t1_byte", got_a[base + i], exp1[i]);

    // 2: transmitter busy when start arrives
    tx_hold = 1'b1;
    base = got_a.size();
    pulse_start_a();
    tick(20);
    chk("t2_no_tx_while_busy", got_a.size() - base, 0);
    tx_hold = 1'b0;
    wait_bytes_a(base + 1);
    chk("t2_first_byte", got_a[base], 8'h11);
    wait_done_a();
    tick(3);

    // 3: bank write while reg0 is being sent
    base = got_a.size();
    pulse_start_a();
    wait_bytes_a(base + 2);
    mem[0] = 32'hFFFFFFFF;
    wait_done_a();
    tick(3);
    for (int i = 0; i < 4; i++) chk("t3_snapshot_byte", got_a[base + i], exp1[i]);
    mem[0] = 32'h11223344;

    // 4: second start mid-dump is dropped
    base = got_a.size(); d0 = n_done_a;
    pulse_start_a();
    wait_bytes_a(base + 3);
    pulse_start_a();
    wait_done_a();
    tick(30);
    chk("t4_count", got_a.size() - base, 8);
    chk("t4_done_count", n_done_a - d0, 1);

    // 5: reset while waiting for byte 3 to finish
    base = got_a.size();
    pulse_start_a();
    wait_bytes_a(base + 4);
    tick(4);
    rst_a = 1'b1;
    tick(1);
    rst_a = 1'b0;
    chk("t5_busy", busy_a, 0);
    chk("t5_txStart", txStart_a, 0);
    chk("t5_regAddr", regAddr_a, 0);
    base2 = got_a.size();
    pulse_start_a();
    wait_bytes_a(base2 + 1);
    chk("t5_restart_byte0", got_a[base2], 8'h11);
    wait_done_a();
    tick(3);
    chk("t5_restart_count", got_a.size() - base2, 8);

    // randomized runs: random data, TX timing, mid-dump writes and start pulses
    for (int r = 0; r < 10; r++) begin
      mem[0] = $urandom;
      mem[1] = $urandom;
      tx_len = $urandom_range(1, 6);
      base = got_a.size(); d0 = n_done_a;
      pulse_start_a();
      wait_bytes_a(base + 2);
      if ($urandom_range(0, 1) == 1) mem[0] = $urandom;
      if ($urandom_range(0, 1) == 1) pulse_start_a();
      wait_bytes_a(base + 6);
      if ($urandom_range(0, 1) == 1) mem[1] = $urandom;
      wait_done_a();
      tick($urandom_range(1, 4));
      chk("rand_count", got_a.size() - base, 8);
      chk("rand_done_count", n_done_a - d0, 1);
    end

    // 6: default parameters, zero bank, full 32-register sweep
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    t = 0;
    while (nb_done == 0 && t < 5000) begin
      tick(1);
      t++;
    end
    tick(5);
    chk("b_byte_count", nb_bytes, 128);
    chk("b_done_count", nb_done, 1);
    chk("b_max_regAddr", nb_maxaddr, 31);
    chk("b_end_regAddr", regAddr_b, 0);
    chk("b_end_busy", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
